// File: rtl/mips_muldiv_if.sv
// Pipeline-side bundle for the HI/LO multiply/divide unit: issue, MTHI/MTLO writes,
// and status/result readback.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fix-up in a final cycle.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mips_muldiv_if.slave  bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;
    logic               r_sign_ab;
    logic               r_sign_a;
    logic               r_b_zero;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic neg);
        if (neg) begin
            return {WIDTH{1'b0}} - v;
        end else begin
            return v;
        end
    endfunction

    // Operand magnitudes, one datapath step, and the final sign-corrected results
    always_comb begin
        w_signed = ~bus.op[0];
        w_mag_a  = f_mag(bus.a, w_signed & bus.a[WIDTH-1]);
        w_mag_b  = f_mag(bus.b, w_signed & bus.b[WIDTH-1]);
        w_add    = {1'b0, r_p[2*WIDTH-1:WIDTH]}
                 + (r_p[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_trial  = r_p[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
        if (!r_is_div) begin
            w_step = {w_add, r_p[WIDTH-1:1]};
        end else if (w_trial[WIDTH]) begin
            w_step = {r_p[2*WIDTH-2:0], 1'b0};
        end else begin
            w_step = {w_trial[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
        end
        w_prod = r_sign_ab ? ({(2*WIDTH){1'b0}} - r_p) : r_p;
        w_quo  = f_mag(r_p[WIDTH-1:0], r_sign_ab);
        w_rem  = f_mag(r_p[2*WIDTH-1:WIDTH], r_sign_a);
    end

    // Control FSM with registered status and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_p       <= {(2*WIDTH){1'b0}};
            r_m       <= {WIDTH{1'b0}};
            r_is_div  <= 1'b0;
            r_sign_ab <= 1'b0;
            r_sign_a  <= 1'b0;
            r_b_zero  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // Start takes priority; any coincident MTHI/MTLO is dropped
                        r_is_div  <= bus.op[1];
                        r_sign_ab <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_sign_a  <= w_signed & bus.a[WIDTH-1];
                        r_b_zero  <= bus.op[1] & (bus.b == {WIDTH{1'b0}});
                        r_m       <= bus.op[1] ? w_mag_b : w_mag_a;
                        r_p       <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
                        r_cnt     <= {CW{1'b0}};
                        r_busy    <= 1'b1;
                        r_state   <= ST_CALC;
                    end else begin
                        if (bus.mthi) begin
                            r_hi <= bus.wdata;
                        end
                        if (bus.mtlo) begin
                            r_lo <= bus.wdata;
                        end
                    end
                end
                ST_CALC: begin
                    r_p   <= w_step;
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == LAST) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (!r_is_div) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_b_zero) begin
                        r_dbz <= 1'b1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                    r_cnt   <= {CW{1'b0}};
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.dbz  = r_dbz;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mips_muldiv.sv
// Directed, table-driven bench for mips_muldiv with hand-computed HI/LO results,
// plus sequences for MTHI/MTLO, divide-by-zero, stray start and mid-op reset.
module tb_mips_muldiv;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_err;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        string       nm;
    } vec_t;

    vec_t vecs [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // inj: 0 none, 1 stray start while busy, 2 mthi/mtlo while busy, 3 mthi/mtlo with start
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input logic ed,
                          input int inj, input string nm);
        int busy_cnt;
        bit got;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        if (inj == 3) begin
            bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hCAFEF00D;
        end
        @(negedge clk);
        bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            if (bus.done) begin
                got = 1'b1;
            end else begin
                if (bus.busy) busy_cnt++;
                if (c == 5 && inj == 1) begin
                    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'h0000_0001; bus.b = 32'h0000_0000;
                end
                if (c == 5 && inj == 2) begin
                    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hDEADBEEF;
                end
                if (c == 6) begin
                    bus.start = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk({nm, " done_seen"}, 64'(got), 64'd1);
        chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        chk({nm, " busy_at_done"}, 64'(bus.busy), 64'd0);
        chk({nm, " hi"}, 64'(bus.hi), 64'(eh));
        chk({nm, " lo"}, 64'(bus.lo), 64'(el));
        chk({nm, " dbz"}, 64'(bus.dbz), 64'(ed));
        @(negedge clk);
        chk({nm, " done_one_cycle"}, {62'd0, bus.done, bus.dbz}, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = 32'h0; bus.b = 32'h0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = 32'h0;

        vecs[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max"};
        vecs[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg3x7"};
        vecs[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, "mult_minxmin"};
        vecs[3] = '{2'b00, 32'h00000005, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFEC, 1'b0, "mult_5xneg4"};
        vecs[4] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_neg7by2"};
        vecs[5] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, "divu_big"};
        vecs[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_wrap"};
        vecs[7] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, "divu_100by7"};
        vecs[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_7byneg2"};

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.dbz, bus.hi[30:0], bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz, 0, vecs[i].nm);
        end

        // Idle MTHI/MTLO, then divide by zero with an MTHI/MTLO attempt while busy
        @(negedge clk);
        bus.mthi = 1'b1; bus.wdata = 32'h12345678;
        @(negedge clk);
        bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h9ABCDEF0;
        @(negedge clk);
        bus.mtlo = 1'b0;
        chk("mthi_idle", 64'(bus.hi), 64'h12345678);
        chk("mtlo_idle", 64'(bus.lo), 64'h9ABCDEF0);
        run_op(2'b10, 32'h00000055, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 1'b1, 2, "div_by_zero");
        run_op(2'b11, 32'h00000055, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 1'b1, 0, "divu_by_zero");

        run_op(2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 3, "start_beats_mt");
        run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1, "stray_start");

        // Reset asserted mid-operation
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'd7; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midop_reset", {bus.busy, bus.done, bus.dbz, bus.hi[28:0], bus.lo}, 64'd0);
        chk("midop_reset_hi", 64'(bus.hi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0, "after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Iterative multi-cycle multiply/divide unit for the MIPS core, holding the architectural HI/LO registers. It complements the single-cycle integer ALU by executing MULT, MULTU, DIV and DIVU, which that ALU does not implement. It also serves MTHI/MTLO writes and MFHI/MFLO reads. The pipeline issues an operation with a start pulse, stalls any HI/LO access while busy is high, and reads results once done has pulsed.

Parameters:
WIDTH, 32, operand width and width of HI/LO; the iteration count equals WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin the operation selected by op
op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
a  input  WIDTH  operand rs (multiplicand or dividend)
b  input  WIDTH  operand rt (multiplier or divisor)
mthi  input  1  write wdata to HI
mtlo  input  1  write wdata to LO
wdata  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle
dbz  output  1  one-cycle pulse coincident with done when a DIV/DIVU had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): hi=0, lo=0, busy=0, done=0, dbz=0, FSM goes to IDLE, iteration counter=0. Assertion mid-operation aborts the operation; no partial result is written.
- FSM states:
  - IDLE: start=1 captures op, a and b. Signed ops convert operands to magnitudes and record the result signs. Next state is CALC with count=0 and busy=1.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, for WIDTH cycles. Next state is FIX after count==WIDTH-1.
  - FIX: applies the sign correction and writes HI/LO. Next state is IDLE, busy deasserts, and done=1 for exactly one cycle.
- Latency: start sampled at edge E0; busy high after E0 through E(WIDTH+1); HI/LO updated and done high after E(WIDTH+1), i.e. 33 edges for WIDTH=32. Back-to-back operation: start may be asserted in the same cycle done is high.
- start while busy is ignored; the in-flight operation continues unaffected.
- mthi/mtlo:
  - When idle, write wdata to hi/lo at the next edge; both may be asserted together.
  - While busy, they are ignored.
  - If start and mthi/mtlo are asserted in the same idle cycle, start wins and the writes are dropped.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product, signed for MULT and unsigned for MULTU.
- Divide results: lo = quotient, hi = remainder.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wrap, no flag).
- Divide by zero (b==0 on DIV/DIVU): same latency as a normal divide, hi/lo unchanged, dbz=1 alongside done.
- done and dbz are never high outside the FIX-to-IDLE cycle.
- hi/lo change only at reset, on a FIX write, or on an idle mthi/mtlo write.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy for 33 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001, dbz=0.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=0x80000000, b=0xFFFFFFFF -> lo=0, hi=0x80000000.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=100, b=7 -> lo=14, hi=2.
- Idle mthi/mtlo load hi=0x12345678, lo=0x9ABCDEF0, then DIV with b=0 -> done and dbz pulse together, hi/lo unchanged; mthi asserted while busy -> no effect.
- Start a MULTU, pulse start with different operands at cycle 5 -> ignored, original result produced; assert rst_n=0 at cycle 10 of a new op -> busy, done, hi and lo all 0 immediately, and a subsequent op runs normally.
